// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt/exception controller.
package irq_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } irq_state_t;

  localparam int CAUSE_IRQ_BIT = 31;
  localparam int CAUSE_ID_LSB  = 0;
  localparam int CAUSE_ID_W    = 8;

  localparam logic [3:0] EXC_OVF = 4'h1;
  localparam logic [3:0] EXC_ILL = 4'h2;

endpackage

// File: rtl/irq_ctrl_if.sv
// Bus bundle between the PC/CPU side (master) and irq_ctrl (slave).
// irq_count exists only when IRQ_STATS_EN is defined.
interface irq_ctrl_if #(
  parameter int NUM_IRQ = 4,
  parameter int EXC_W   = 4
);
  logic [NUM_IRQ-1:0] irq_in;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic               exc_req;
  logic [EXC_W-1:0]   exc_code;
  logic               eret;
  logic [31:0]        ia;
  logic               irq;
  logic               Exception;
  logic [31:0]        epc;
  logic [31:0]        cause;
  logic               in_handler;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;
`ifdef IRQ_STATS_EN
  logic [15:0]        irq_count;
`endif

  modport master (
    output irq_in, mask_we, mask_wdata, exc_req, exc_code, eret, ia,
    input  irq, Exception, epc, cause, in_handler, pending, mask
`ifdef IRQ_STATS_EN
    , input irq_count
`endif
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata, exc_req, exc_code, eret, ia,
    output irq, Exception, epc, cause, in_handler, pending, mask
`ifdef IRQ_STATS_EN
    , output irq_count
`endif
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder.
module irq_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [7:0]   idx
);
  logic [N:0]   seen;
  logic [N-1:0] onehot;

  assign seen[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chain
      assign seen[gi+1]  = seen[gi] | req[gi];
      assign onehot[gi]  = req[gi] & ~seen[gi];
    end
  endgenerate

  assign valid = seen[N];

  always_comb begin
    idx = 8'd0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = 8'(i);
    end
  end
endmodule

// File: rtl/irq_ctrl.sv
// Interrupt/exception controller: edge-detects irq lines, arbitrates against
// exceptions and issues one-cycle redirect pulses. Optional feature: IRQ_STATS_EN.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int EXC_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  irq_ctrl_if.slave   bus
);
  irq_state_t         state_q, state_d;
  logic               irq_q, irq_d;
  logic               exc_q, exc_d;
  logic [31:0]        epc_q, epc_d;
  logic [31:0]        cause_q, cause_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] irq_in_q, irq_in_d;
  logic [NUM_IRQ-1:0] eligible, clr;
  logic [31:0]        irq_cause, exc_cause;
  logic               win_valid;
  logic [7:0]         win_idx;

  assign eligible = pending_q & mask_q;

  irq_prio_enc #(.N(NUM_IRQ)) u_prio (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_comb begin
    irq_cause = '0;
    irq_cause[CAUSE_IRQ_BIT] = 1'b1;
    irq_cause[CAUSE_ID_LSB +: CAUSE_ID_W] = win_idx;
    exc_cause = '0;
    exc_cause[CAUSE_ID_LSB +: CAUSE_ID_W] = CAUSE_ID_W'(bus.exc_code);
  end

  always_comb begin
    state_d = state_q;
    irq_d   = 1'b0;
    exc_d   = 1'b0;
    epc_d   = epc_q;
    cause_d = cause_q;
    clr     = '0;
    case (state_q)
      RUN: begin
        if (bus.exc_req) begin
          exc_d   = 1'b1;
          epc_d   = bus.ia;
          cause_d = exc_cause;
          state_d = HANDLER;
        end else if (win_valid) begin
          irq_d   = 1'b1;
          epc_d   = bus.ia;
          cause_d = irq_cause;
          clr     = NUM_IRQ'(1) << win_idx;
          state_d = HANDLER;
        end
      end
      HANDLER: begin
        // An exception racing eret is a fresh entry, so it may overwrite epc/cause.
        if (bus.exc_req) begin
          exc_d = 1'b1;
          if (bus.eret) begin
            epc_d   = bus.ia;
            cause_d = exc_cause;
          end
        end else if (bus.eret) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // Set is ORed in after the clear so a same-edge re-trigger is not lost.
    pending_d = (pending_q & ~clr) | (bus.irq_in & ~irq_in_q);
    mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;
    irq_in_d  = bus.irq_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      irq_q     <= 1'b0;
      exc_q     <= 1'b0;
      epc_q     <= '0;
      cause_q   <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      irq_in_q  <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      exc_q     <= exc_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irq_in_q  <= irq_in_d;
    end
  end

  assign bus.irq        = irq_q;
  assign bus.Exception  = exc_q;
  assign bus.epc        = epc_q;
  assign bus.cause      = cause_q;
  assign bus.in_handler = (state_q == HANDLER);
  assign bus.pending    = pending_q;
  assign bus.mask       = mask_q;

`ifdef IRQ_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((irq_d || exc_d) && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bus.irq_count = cnt_q;
`endif
endmodule
